input_conditioner: RTL and testbench
====================================

// Module: input_conditioner
// PURPOSE
//  Front-end for the board push-buttons and slide switches, sitting directly upstream
//  of the PCIe system's button and inport PIO inputs.
//  - Synchronises raw KEY/SW pins and debounces every bit.
//  - Packs the results into the 32-bit button word and 16-bit switch word the PIOs sample.
//  - Keeps a wrapping press-event counter, so host polling never misses a short press.
// PARAMETERS
//  N_KEYS           4          number of push-buttons, 1..8
//  N_SW             16         number of slide switches, 1..16
//  DEBOUNCE_CYCLES  1000000    consecutive mismatch cycles before a bit flips, >=2 (20 ms at 50 MHz)
//  CNT_W            $clog2(DEBOUNCE_CYCLES)   debounce counter width, derived
// PORTS
//  clk          in   1       system clock, the same clock as the PCIe application side
//  reset        in   1       asynchronous, active-high reset
//  key_n_raw    in   N_KEYS  raw push-buttons, active-low, asynchronous to clk
//  sw_raw       in   N_SW    raw slide switches, active-high, asynchronous to clk
//  button_word  out  32      to button PIO: [N_KEYS-1:0] debounced pressed (1=pressed),
//                            [15:8] reserved 0, [23:16] press_count, [31:24] 0
//  switch_word  out  16      to inport PIO: [N_SW-1:0] debounced switches, upper bits 0
//  press_pulse  out  N_KEYS  one-cycle strobe per key on a debounced press
// BEHAVIOUR
//  Clock/reset
//  - One clock; reset is asynchronous and active-high.
//  - All state is cleared on reset assertion, with no clock needed.
//  - Reset values:
//    - button_word = 0, switch_word = 0, press_pulse = 0.
//    - Key sync FFs = 1 (released); switch sync FFs = 0.
//    - All counters = 0.
//  Per bit
//  - Two-FF synchroniser: sync1 <= raw, sync2 <= sync1.
//  - Keys are inverted after sync2, so the internal polarity is 1 = pressed.
//  - Debouncer holds stable and cnt:
//    - sync2 == stable: cnt <= 0.
//    - sync2 != stable and cnt < DEBOUNCE_CYCLES-1: cnt <= cnt+1.
//    - sync2 != stable and cnt == DEBOUNCE_CYCLES-1: stable <= sync2, cnt <= 0.
//  - Any bounce back to the stable value restarts the count from 0. No partial credit.
//  - Latency: a raw change first sampled at edge 1 updates stable at edge DEBOUNCE_CYCLES+2,
//    provided the pin holds throughout.
//  Press events
//  - press_pulse[i] = 1 for exactly the one cycle after stable_key[i] goes 0->1 (registered).
//  - Releases produce no pulse.
//  - press_count (8-bit) increments by the number of keys pulsing in that cycle.
//    Simultaneous presses each count. Wraps 255 -> 0 with no flag.
//  - Pulse and count update on the same edge.
//  Output registers
//  - button_word and switch_word are registered.
//  - Unused bits are constant 0.
//  - Each word changes only on a clock edge, so the PIO never samples a half-updated word.
//  Reset mid-operation
//  - In-progress debounce counts are discarded and press_count returns to 0.
//  - A key held through reset release reports pressed DEBOUNCE_CYCLES+2 cycles later.
//    This also produces one press_pulse and a count increment.
// STRUCTURE
//  - Shared package io_cond_pkg:
//    - BUTTON_WORD_W=32, PRESS_CNT_LSB=16, PRESS_CNT_W=8, SWITCH_WORD_W=16.
//    - Default DEBOUNCE_CYCLES.
//  - Sub-module debounce_bit: the synchroniser plus debouncer for one bit.
//    - Parameters DEBOUNCE_CYCLES and RESET_VAL.
//    - Ports clk, reset, raw, stable.
//    - Instantiated N_KEYS+N_SW times by generate.
//  - The top level handles key inversion, edge detect, press_count and word packing.
// TESTING  (DEBOUNCE_CYCLES=8)
//  1. Reset released, key_n_raw=4'hF, sw_raw=0
//     -> button_word==0, switch_word==0, press_pulse==0 for 20 cycles.
//  2. key_n_raw[0] 1->0, held
//     -> button_word[0]=1 at edge 10; press_pulse[0]=1 for 1 cycle at edge 11; button_word[23:16]=1.
//  3. key_n_raw[1] toggles every 3 cycles for 30 cycles, then held low
//     -> no change during bouncing; bit 1 sets 10 cycles after the final edge; one pulse only.
//  4. Keys 2 and 3 pressed on the same cycle
//     -> both pulses on the same edge; press_count advances by 2.
//  5. 256 debounced presses of key 0 starting from press_count 0
//     -> press_count wraps to 0; bits [31:24] and [15:8] remain 0.
//  6. sw_raw=16'hA5C3 stable, then reset asserted mid-debounce at cycle 5
//     -> switch_word=0 immediately; after release, switch_word=16'hA5C3 at edge 10.

Source files
------------

// File: rtl/io_cond_pkg.sv
// ----------------------------------------------------------------------------
// io_cond_pkg : shared widths, field positions and helpers for input_conditioner
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package io_cond_pkg;

    localparam int BUTTON_WORD_W           = 32;
    localparam int PRESS_CNT_LSB           = 16;
    localparam int PRESS_CNT_W             = 8;
    localparam int SWITCH_WORD_W           = 16;
    localparam int MAX_KEYS                = 8;
    localparam int DEBOUNCE_CYCLES_DEFAULT = 1000000;

    typedef logic [PRESS_CNT_W-1:0] press_cnt_t;

    function automatic logic [3:0] count_ones8(input logic [MAX_KEYS-1:0] v);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < MAX_KEYS; i++) begin
            n = n + {3'b000, v[i]};
        end
        return n;
    endfunction

endpackage

`default_nettype wire

// File: rtl/debounce_bit.sv
// ----------------------------------------------------------------------------
// debounce_bit : two-FF synchroniser followed by a consecutive-match debouncer
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module debounce_bit #(
    parameter int   DEBOUNCE_CYCLES = 1000000,
    parameter logic RESET_VAL       = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic stable
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             stable_q, stable_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Any return to the stable value wipes the count; only an unbroken run flips the bit.
    always_comb begin
        sync1_d  = raw;
        sync2_d  = sync1_q;
        stable_d = stable_q;
        cnt_d    = '0;
        if (sync2_q != stable_q) begin
            if (cnt_q == CNT_LAST) begin
                stable_d = sync2_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q  <= RESET_VAL;
            sync2_q  <= RESET_VAL;
            stable_q <= RESET_VAL;
            cnt_q    <= '0;
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

    assign stable = stable_q;

endmodule

`default_nettype wire

// File: rtl/input_conditioner.sv
// ----------------------------------------------------------------------------
// input_conditioner : debounced KEY/SW front-end packing PIO button/switch words
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module input_conditioner
    import io_cond_pkg::*;
#(
    parameter int N_KEYS          = 4,
    parameter int N_SW            = 16,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [N_KEYS-1:0]        key_n_raw,
    input  logic [N_SW-1:0]          sw_raw,
    output logic [BUTTON_WORD_W-1:0] button_word,
    output logic [SWITCH_WORD_W-1:0] switch_word,
    output logic [N_KEYS-1:0]        press_pulse
);

    logic [N_KEYS-1:0]   key_stable_n;
    logic [N_KEYS-1:0]   key_pressed;
    logic [N_SW-1:0]     sw_stable;

    logic [N_KEYS-1:0]   key_prev_q, key_prev_d;
    logic [N_KEYS-1:0]   press_pulse_q, press_pulse_d;
    press_cnt_t          press_cnt_q, press_cnt_d;
    logic [MAX_KEYS-1:0] rise_ext;

    // Keys debounce in raw (active-low) polarity so reset parks them as released.
    for (genvar i = 0; i < N_KEYS; i++) begin : g_key
        debounce_bit #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .RESET_VAL       (1'b1)
        ) u_db (
            .clk    (clk),
            .reset  (reset),
            .raw    (key_n_raw[i]),
            .stable (key_stable_n[i])
        );
    end

    for (genvar i = 0; i < N_SW; i++) begin : g_sw
        debounce_bit #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .RESET_VAL       (1'b0)
        ) u_db (
            .clk    (clk),
            .reset  (reset),
            .raw    (sw_raw[i]),
            .stable (sw_stable[i])
        );
    end

    assign key_pressed = ~key_stable_n;

    always_comb begin
        key_prev_d    = key_pressed;
        press_pulse_d = key_pressed & ~key_prev_q;
        rise_ext      = '0;
        rise_ext[N_KEYS-1:0] = press_pulse_d;
        press_cnt_d   = press_cnt_q + PRESS_CNT_W'(count_ones8(rise_ext));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            key_prev_q    <= '0;
            press_pulse_q <= '0;
            press_cnt_q   <= '0;
        end else begin
            key_prev_q    <= key_prev_d;
            press_pulse_q <= press_pulse_d;
            press_cnt_q   <= press_cnt_d;
        end
    end

    // Every field below is a flop output, so each word only moves on a clock edge.
    always_comb begin
        button_word = '0;
        button_word[N_KEYS-1:0] = key_pressed;
        button_word[PRESS_CNT_LSB +: PRESS_CNT_W] = press_cnt_q;
        switch_word = '0;
        switch_word[N_SW-1:0] = sw_stable;
    end

    assign press_pulse = press_pulse_q;

endmodule

`default_nettype wire

// File: tb/tb_input_conditioner.sv
// ----------------------------------------------------------------------------
// tb_input_conditioner : directed scoreboard bench for input_conditioner
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_input_conditioner;

    localparam int N_KEYS = 4;
    localparam int N_SW   = 16;
    localparam int DB     = 8;

    localparam int SEL_BW = 0;
    localparam int SEL_SW = 1;
    localparam int SEL_PP = 2;

    logic              clk;
    logic              reset;
    logic [N_KEYS-1:0] key_n_raw;
    logic [N_SW-1:0]   sw_raw;
    logic [31:0]       button_word;
    logic [15:0]       switch_word;
    logic [N_KEYS-1:0] press_pulse;

    typedef struct {
        int          at;
        int          sel;
        logic [31:0] mask;
        logic [31:0] val;
        string       tag;
    } exp_t;

    exp_t sb[$];
    int   cyc;
    int   total;
    int   bad;

    input_conditioner #(
        .N_KEYS          (N_KEYS),
        .N_SW            (N_SW),
        .DEBOUNCE_CYCLES (DB)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .key_n_raw   (key_n_raw),
        .sw_raw      (sw_raw),
        .button_word (button_word),
        .switch_word (switch_word),
        .press_pulse (press_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish (observed=timeout expected=finish)");
        $fatal(1, "watchdog");
    end

    task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Expectation k edges after the current sample point, kept ordered by cycle.
    task automatic push_exp(input int k, input int sel, input logic [31:0] mask,
                            input logic [31:0] val, input string tag);
        exp_t e;
        int   pos;
        e.at   = cyc + k;
        e.sel  = sel;
        e.mask = mask;
        e.val  = val & mask;
        e.tag  = tag;
        pos = sb.size();
        for (int i = 0; i < sb.size(); i++) begin
            if (sb[i].at > e.at) begin
                pos = i;
                break;
            end
        end
        sb.insert(pos, e);
    endtask

    task automatic drain();
        exp_t        e;
        logic [31:0] obs;
        while (sb.size() > 0 && sb[0].at <= cyc) begin
            e = sb.pop_front();
            case (e.sel)
                SEL_BW:  obs = button_word;
                SEL_SW:  obs = {16'h0, switch_word};
                default: obs = {28'h0, press_pulse};
            endcase
            if (e.at != cyc) obs = 32'hDEAD_BEEF;
            cmp(e.tag, obs & e.mask, e.val);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            cyc++;
            drain();
        end
    endtask

    initial begin
        cyc       = 0;
        total     = 0;
        bad       = 0;
        reset     = 1'b0;
        key_n_raw = 4'hF;
        sw_raw    = 16'h0;

        // Reset acts without any clock edge.
        #2 reset = 1'b1;
        #1;
        cmp("rst_bw", button_word, 32'h0);
        cmp("rst_sw", {16'h0, switch_word}, 32'h0);
        cmp("rst_pp", {28'h0, press_pulse}, 32'h0);
        tick(3);
        reset = 1'b0;

        // 1: idle after reset
        for (int k = 1; k <= 20; k++) begin
            push_exp(k, SEL_BW, 32'hFFFF_FFFF, 32'h0, "idle_bw");
            push_exp(k, SEL_SW, 32'hFFFF_FFFF, 32'h0, "idle_sw");
            push_exp(k, SEL_PP, 32'hFFFF_FFFF, 32'h0, "idle_pp");
        end
        tick(20);

        // 2: key 0 pressed and held
        key_n_raw[0] = 1'b0;
        push_exp(9,  SEL_BW, 32'h1,         32'h0,         "k0_before");
        push_exp(10, SEL_BW, 32'h1,         32'h1,         "k0_set");
        push_exp(10, SEL_PP, 32'hF,         32'h0,         "k0_pp_early");
        push_exp(11, SEL_PP, 32'hF,         32'h1,         "k0_pp");
        push_exp(12, SEL_PP, 32'hF,         32'h0,         "k0_pp_end");
        push_exp(10, SEL_BW, 32'h00FF_0000, 32'h0,         "k0_cnt_pre");
        push_exp(11, SEL_BW, 32'h00FF_0000, 32'h0001_0000, "k0_cnt");
        tick(12);

        // 3: key 1 bounces every 3 cycles, then settles low
        for (int k = 1; k <= 30; k++) begin
            push_exp(k, SEL_BW, 32'h2, 32'h0, "bounce_bw");
            push_exp(k, SEL_PP, 32'hF, 32'h0, "bounce_pp");
        end
        for (int j = 0; j < 10; j++) begin
            key_n_raw[1] = (j % 2 == 1);
            tick(3);
        end
        key_n_raw[1] = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            push_exp(k, SEL_PP, 32'hF, 32'h0, "k1_pp_quiet");
        end
        push_exp(9,  SEL_BW, 32'h2,         32'h0,         "k1_before");
        push_exp(10, SEL_BW, 32'h2,         32'h2,         "k1_set");
        push_exp(11, SEL_PP, 32'hF,         32'h2,         "k1_pp");
        push_exp(12, SEL_PP, 32'hF,         32'h0,         "k1_pp_end");
        push_exp(11, SEL_BW, 32'h00FF_0000, 32'h0002_0000, "k1_cnt");
        tick(12);

        // 4: keys 2 and 3 together
        key_n_raw = 4'h0;
        push_exp(9,  SEL_BW, 32'hF,         32'h3,         "k23_before");
        push_exp(10, SEL_BW, 32'hF,         32'hF,         "k23_set");
        push_exp(10, SEL_PP, 32'hF,         32'h0,         "k23_pp_early");
        push_exp(11, SEL_PP, 32'hF,         32'hC,         "k23_pp");
        push_exp(12, SEL_PP, 32'hF,         32'h0,         "k23_pp_end");
        push_exp(11, SEL_BW, 32'h00FF_0000, 32'h0004_0000, "k23_cnt");
        tick(12);

        // releases: bits clear, no pulse, count unchanged
        key_n_raw = 4'hF;
        for (int k = 1; k <= 12; k++) begin
            push_exp(k, SEL_PP, 32'hF, 32'h0, "rel_pp");
        end
        push_exp(9,  SEL_BW, 32'hF,         32'hF,         "rel_before");
        push_exp(10, SEL_BW, 32'hF,         32'h0,         "rel_clr");
        push_exp(12, SEL_BW, 32'h00FF_0000, 32'h0004_0000, "rel_cnt");
        tick(12);

        // asynchronous reset mid-cycle clears the count
        #2 reset = 1'b1;
        #1;
        cmp("async_rst_bw", button_word, 32'h0);
        tick(2);
        reset = 1'b0;
        tick(2);

        // 5: 256 presses of key 0 wrap the count
        for (int n = 0; n < 256; n++) begin
            key_n_raw[0] = 1'b0;
            push_exp(11, SEL_BW, 32'h00FF_0000, {8'h0, 8'(n + 1), 16'h0}, "wrap_cnt");
            push_exp(11, SEL_BW, 32'hFF00_FF00, 32'h0, "wrap_rsvd");
            tick(11);
            key_n_raw[0] = 1'b1;
            tick(12);
        end

        // 6: switches and a held key interrupted by reset mid-debounce
        sw_raw       = 16'hA5C3;
        key_n_raw[2] = 1'b0;
        push_exp(5, SEL_SW, 32'hFFFF, 32'h0, "sw_pre_rst");
        tick(5);
        reset = 1'b1;
        #1;
        cmp("sw_in_rst", {16'h0, switch_word}, 32'h0);
        cmp("bw_in_rst", button_word, 32'h0);
        tick(2);
        reset = 1'b0;
        push_exp(9,  SEL_SW, 32'hFFFF,      32'h0,         "sw_before");
        push_exp(10, SEL_SW, 32'hFFFF,      32'hA5C3,      "sw_set");
        push_exp(9,  SEL_BW, 32'h4,         32'h0,         "held_before");
        push_exp(10, SEL_BW, 32'h4,         32'h4,         "held_set");
        push_exp(11, SEL_PP, 32'hF,         32'h4,         "held_pp");
        push_exp(12, SEL_PP, 32'hF,         32'h0,         "held_pp_end");
        push_exp(11, SEL_BW, 32'h00FF_0000, 32'h0001_0000, "held_cnt");
        tick(12);

        for (int i = 0; i < 50 && sb.size() > 0; i++) begin
            tick(1);
        end
        while (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            total++;
            bad++;
            $display("FAIL %s: observed=unchecked expected=%h", e.tag, e.val);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
